// File: rtl/rr_arb_mux.sv
// Arbiter-mux over 2^M valid/ready channels: round-robin or fixed priority,
// packet locking on per-channel last flags, one registered output stage.
//
//   state    | meaning
//   UNLOCKED | any valid channel may win the next grant
//   LOCKED   | mid-packet; only lock_ch_q may be granted until its last beat
module rr_arb_mux #(
  parameter int N    = 8,
  parameter int M    = 2,
  parameter int MODE = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [(1<<M)*N-1:0]   d,
  input  logic [(1<<M)-1:0]     in_valid,
  input  logic [(1<<M)-1:0]     in_last,
  output logic [(1<<M)-1:0]     in_ready,
  output logic [N-1:0]          y,
  output logic                  out_last,
  output logic [M-1:0]          out_sel,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int C = 1 << M;

  typedef enum logic {UNLOCKED, LOCKED} lock_e;

  lock_e        lock_q, lock_d;
  logic [M-1:0] lock_ch_q, lock_ch_d;
  logic [M-1:0] ptr_q, ptr_d;
  logic [M-1:0] sel_q, sel_d;
  logic [N-1:0] y_q, y_d;
  logic         last_q, last_d;
  logic         valid_q, valid_d;

  logic         load;
  logic         gvalid;
  logic         xfer;
  logic [M-1:0] gidx;
  logic [M-1:0] base;
  logic [M-1:0] idx;
  logic [C-1:0] grant;

  assign load = !valid_q || out_ready;
  assign base = (MODE == 1) ? '0 : ptr_q;

  // Search wraps naturally because idx is M bits wide.
  always_comb begin
    gvalid = 1'b0;
    gidx   = '0;
    idx    = '0;
    if (lock_q == LOCKED) begin
      gidx   = lock_ch_q;
      gvalid = in_valid[lock_ch_q];
    end else begin
      for (int k = 0; k < C; k++) begin
        idx = base + M'(k);
        if (!gvalid && in_valid[idx]) begin
          gvalid = 1'b1;
          gidx   = idx;
        end
      end
    end
  end

  always_comb begin
    grant = '0;
    for (int i = 0; i < C; i++) begin
      grant[i] = gvalid && (gidx == M'(i));
    end
  end

  assign in_ready = grant & {C{load & ~reset}};
  assign xfer     = load & gvalid & ~reset;

  always_comb begin
    lock_d    = lock_q;
    lock_ch_d = lock_ch_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    y_d       = y_q;
    last_d    = last_q;
    valid_d   = valid_q;
    if (load) begin
      valid_d = xfer;
    end
    if (xfer) begin
      y_d    = d[gidx*N +: N];
      last_d = in_last[gidx];
      sel_d  = gidx;
      if (in_last[gidx]) begin
        lock_d = UNLOCKED;
        if (MODE == 0) begin
          ptr_d = gidx + M'(1);
        end
      end else begin
        lock_d    = LOCKED;
        lock_ch_d = gidx;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_q    <= UNLOCKED;
      lock_ch_q <= '0;
      ptr_q     <= '0;
      sel_q     <= '0;
      y_q       <= '0;
      last_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      lock_q    <= lock_d;
      lock_ch_q <= lock_ch_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      y_q       <= y_d;
      last_q    <= last_d;
      valid_q   <= valid_d;
    end
  end

  assign y         = y_q;
  assign out_last  = last_q;
  assign out_sel   = sel_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Scoreboard bench for rr_arb_mux: a round-robin and a fixed-priority instance,
// expected beats queued at stimulus time and popped by per-instance monitors.
module tb_rr_arb_mux;
  localparam int N = 8;
  localparam int M = 2;
  localparam int C = 4;

  logic clk = 1'b0;
  logic reset;

  logic [C*N-1:0] d_a, d_b;
  logic [C-1:0]   v_a, l_a, r_a, v_b, l_b, r_b;
  logic [N-1:0]   y_a, y_b;
  logic           ol_a, ol_b, ov_a, ov_b, ordy_a, ordy_b;
  logic [M-1:0]   os_a, os_b;

  int checks = 0;
  int errors = 0;

  logic [10:0] q_a[$];
  logic [10:0] q_b[$];
  logic [10:0] exp_a, exp_b;

  always #5 clk = ~clk;

  rr_arb_mux #(.N(N), .M(M), .MODE(0)) u_rr (
    .clk(clk), .reset(reset), .d(d_a), .in_valid(v_a), .in_last(l_a),
    .in_ready(r_a), .y(y_a), .out_last(ol_a), .out_sel(os_a),
    .out_valid(ov_a), .out_ready(ordy_a)
  );

  rr_arb_mux #(.N(N), .M(M), .MODE(1)) u_fp (
    .clk(clk), .reset(reset), .d(d_b), .in_valid(v_b), .in_last(l_b),
    .in_ready(r_b), .y(y_b), .out_last(ol_b), .out_sel(os_b),
    .out_valid(ov_b), .out_ready(ordy_b)
  );

  function automatic logic [10:0] pk(input logic [1:0] sel, input logic last,
                                     input logic [7:0] data);
    return {sel, last, data};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!reset && ov_a && ordy_a) begin
      if (q_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_rr: unexpected beat %0h at %0t", {os_a, ol_a, y_a}, $time);
      end else begin
        exp_a = q_a.pop_front();
        chk("sb_rr {sel,last,y}", {21'b0, os_a, ol_a, y_a}, {21'b0, exp_a});
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && ov_b && ordy_b) begin
      if (q_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_fp: unexpected beat %0h at %0t", {os_b, ol_b, y_b}, $time);
      end else begin
        exp_b = q_b.pop_front();
        chk("sb_fp {sel,last,y}", {21'b0, os_b, ol_b, y_b}, {21'b0, exp_b});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset  = 1'b1;
    ordy_a = 1'b1;
    ordy_b = 1'b1;
    v_b = '0; l_b = '0; d_b = '0;
    v_a = 4'hF; l_a = 4'hF; d_a = {8'h43, 8'h32, 8'h21, 8'h10};
    #2;
    chk("reset out_valid", ov_a, 0);
    chk("reset y", y_a, 0);
    chk("reset out_sel", os_a, 0);
    chk("reset in_ready", r_a, 0);

    // Full-valid round-robin with pointer wrap
    q_a.push_back(pk(0, 1, 8'h10));
    q_a.push_back(pk(1, 1, 8'h21));
    q_a.push_back(pk(2, 1, 8'h32));
    q_a.push_back(pk(3, 1, 8'h43));
    q_a.push_back(pk(0, 1, 8'h10));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rr first in_ready", r_a, 4'b0001);
    repeat (5) cyc();
    v_a = '0;
    cyc();
    chk("rr idle out_valid", ov_a, 0);

    // Ch1 3-beat packet with ch0/ch2 contending
    v_a = 4'b0111; l_a = 4'b0101;
    d_a = {8'h00, 8'h2C, 8'hA1, 8'h0B};
    q_a.push_back(pk(1, 0, 8'hA1));
    cyc();
    d_a[15:8] = 8'hA2;
    q_a.push_back(pk(1, 0, 8'hA2));
    #1;
    chk("locked in_ready", r_a, 4'b0010);
    cyc();
    d_a[15:8] = 8'hA3; l_a = 4'b0111;
    q_a.push_back(pk(1, 1, 8'hA3));
    cyc();
    v_a = 4'b0101;
    q_a.push_back(pk(2, 1, 8'h2C));
    q_a.push_back(pk(0, 1, 8'h0B));
    repeat (2) cyc();

    // Locked channel stalls: no bubble-filling from ch0
    v_a = 4'b0011; l_a = 4'b0001;
    d_a = {8'h00, 8'h00, 8'hB1, 8'h0C};
    q_a.push_back(pk(1, 0, 8'hB1));
    cyc();
    v_a = 4'b0001;
    cyc();
    chk("stall in_ready 1", r_a, 4'b0000);
    chk("stall out_valid 1", ov_a, 0);
    cyc();
    chk("stall in_ready 2", r_a, 4'b0000);
    chk("stall out_valid 2", ov_a, 0);
    v_a = 4'b0011; l_a = 4'b0011;
    d_a[15:8] = 8'hB2;
    q_a.push_back(pk(1, 1, 8'hB2));
    q_a.push_back(pk(0, 1, 8'h0C));
    repeat (2) cyc();

    // Backpressure holds the 0x5A beat
    v_a = 4'b0100; l_a = 4'b0100;
    d_a[23:16] = 8'h5A;
    q_a.push_back(pk(2, 1, 8'h5A));
    cyc();
    ordy_a = 1'b0;
    v_a = 4'hF; l_a = 4'hF;
    d_a = {8'h63, 8'h62, 8'h61, 8'h60};
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("bp y", y_a, 8'h5A);
      chk("bp out_sel", os_a, 2);
      chk("bp out_last", ol_a, 1);
      chk("bp out_valid", ov_a, 1);
      chk("bp in_ready", r_a, 4'b0000);
      cyc();
      v_a = (i % 2 == 0) ? 4'b0101 : 4'b1010;
      l_a = ~l_a;
      d_a = d_a ^ 32'hFFFF_FFFF;
      #1;
    end
    chk("bp y end", y_a, 8'h5A);
    chk("bp in_ready end", r_a, 4'b0000);
    v_a = 4'hF; l_a = 4'hF;
    d_a = {8'h63, 8'h62, 8'h61, 8'h60};
    ordy_a = 1'b1;
    q_a.push_back(pk(3, 1, 8'h63));
    #1;
    chk("bp release in_ready", r_a, 4'b1000);
    cyc();
    v_a = '0;
    cyc();

    // Fixed priority starves ch3 until ch1 drops
    v_b = 4'b1010; l_b = 4'hF;
    d_b = {8'h33, 8'h00, 8'h11, 8'h00};
    q_b.push_back(pk(1, 1, 8'h11));
    q_b.push_back(pk(1, 1, 8'h11));
    q_b.push_back(pk(1, 1, 8'h11));
    #1;
    chk("fp in_ready", r_b, 4'b0010);
    repeat (3) cyc();
    v_b = 4'b1000;
    q_b.push_back(pk(3, 1, 8'h33));
    #1;
    chk("fp ch3 in_ready", r_b, 4'b1000);
    cyc();
    v_b = '0;
    cyc();

    // Reset mid-packet with a beat on the output
    v_a = 4'b0100; l_a = 4'b0000;
    d_a[23:16] = 8'hC2;
    q_a.push_back(pk(2, 0, 8'hC2));
    cyc();
    v_a = '0;
    @(negedge clk);
    #1;
    chk("pre-reset out_valid", ov_a, 1);
    chk("pre-reset out_sel", os_a, 2);
    reset = 1'b1;
    #1;
    chk("async reset out_valid", ov_a, 0);
    chk("async reset y", y_a, 0);
    chk("async reset out_sel", os_a, 0);
    v_a = 4'hF; l_a = 4'hF;
    d_a = {8'h43, 8'h32, 8'h21, 8'h10};
    #1;
    chk("in reset in_ready", r_a, 4'b0000);
    q_a.push_back(pk(0, 1, 8'h10));
    q_a.push_back(pk(1, 1, 8'h21));
    q_a.push_back(pk(2, 1, 8'h32));
    q_a.push_back(pk(3, 1, 8'h43));
    @(negedge clk);
    reset = 1'b0;
    repeat (4) cyc();
    v_a = '0;
    repeat (3) cyc();

    chk("rr queue drained", q_a.size(), 0);
    chk("fp queue drained", q_b.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
